// File: rtl/car_pkg.sv
// car_pkg: shared definitions for the obstacle-avoidance sequencer.
//   state_t    : FSM state codes as seen on the State output
//   MOT_*      : two-bit wheel command encodings
//   motor_t    : left/right wheel command pair
//   motor_cmd  : wheel commands implied by a state and turn direction
//   div_of     : clock cycles per tick, truncating, never below 1
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_STOP = 3'd2,
    ST_BACK = 3'd3,
    ST_TURN = 3'd4
  } state_t;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] r;
  } motor_t;

  // Turning right spins the left wheel forward and the right wheel back.
  function automatic motor_t motor_cmd(input logic [2:0] st, input logic turn_right);
    motor_t m;
    m.l = MOT_STOP;
    m.r = MOT_STOP;
    case (st)
      ST_FWD:  begin m.l = MOT_FWD; m.r = MOT_FWD; end
      ST_BACK: begin m.l = MOT_REV; m.r = MOT_REV; end
      ST_TURN: begin
        m.l = turn_right ? MOT_FWD : MOT_REV;
        m.r = turn_right ? MOT_REV : MOT_FWD;
      end
      default: ;
    endcase
    return m;
  endfunction

  function automatic int div_of(input int clk_hz, input int tick_hz);
    return ((clk_hz / tick_hz) < 1) ? 1 : (clk_hz / tick_hz);
  endfunction

endpackage

// File: rtl/avoid_sequencer_tick_gen.sv
// tick_gen: phase timing base.
//   CLK_50M : clock
//   CLR     : synchronous active-high reset
//   Restart : clears the cycle counter; counting resumes on the next cycle
//   Tick    : one-cycle pulse on the DIV-th cycle after Restart, then every DIV
module tick_gen
  import car_pkg::*;
#(
  parameter int CLK_Freq  = 100000000,
  parameter int TICK_Freq = 10
) (
  input  logic CLK_50M,
  input  logic CLR,
  input  logic Restart,
  output logic Tick
);

  localparam int DIV = div_of(CLK_Freq, TICK_Freq);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_50M) begin
    if (CLR || Restart) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  // With DIV=1 the counter sits at 0 and every cycle is a tick.
  assign Tick = (cnt == LAST);

endmodule

// File: rtl/avoid_sequencer.sv
// avoid_sequencer: drive forward until an obstacle, then stop, back up and
// turn away for fixed tick counts before resuming.
//   CLK_50M          : clock
//   CLR              : synchronous active-high reset
//   Enable           : run request; low returns to IDLE
//   Obst_L / Obst_R  : synchronised obstacle sensors
//   Motor_L/Motor_R  : wheel commands (00 stop, 01 fwd, 10 rev)
//   Busy             : high during STOP, BACK, TURN
//   State            : current state code
module avoid_sequencer
  import car_pkg::*;
#(
  parameter int CLK_Freq  = 100000000,
  parameter int TICK_Freq = 10,
  parameter int STOP_T    = 2,
  parameter int BACK_T    = 5,
  parameter int TURN_T    = 4
) (
  input  logic       CLK_50M,
  input  logic       CLR,
  input  logic       Enable,
  input  logic       Obst_L,
  input  logic       Obst_R,
  output logic [1:0] Motor_L,
  output logic [1:0] Motor_R,
  output logic       Busy,
  output logic [2:0] State
);

  localparam int MAX_T = (STOP_T > BACK_T) ? ((STOP_T > TURN_T) ? STOP_T : TURN_T)
                                           : ((BACK_T > TURN_T) ? BACK_T : TURN_T);
  localparam int TW = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  logic [TW-1:0] tcnt, dur;
  logic          tick, restart, in_phase, phase_end, obst;
  logic          dir_right, nxt_dir;
  logic [2:0]    nxt_state;
  motor_t        nxt_mot;

  assign obst     = Obst_L | Obst_R;
  assign in_phase = (State == ST_STOP) || (State == ST_BACK) || (State == ST_TURN);

  always_comb begin
    dur = '0;
    case (State)
      ST_STOP: dur = TW'(STOP_T - 1);
      ST_BACK: dur = TW'(BACK_T - 1);
      ST_TURN: dur = TW'(TURN_T - 1);
      default: ;
    endcase
  end

  assign phase_end = in_phase && tick && (tcnt == dur);
  // Timing restarts on every cycle that precedes a state entry, so the first
  // cycle of a new state is cycle 0 of its phase. Outside phases it is held.
  assign restart   = !in_phase || !Enable || phase_end;

  tick_gen #(.CLK_Freq(CLK_Freq), .TICK_Freq(TICK_Freq)) u_tick (
    .CLK_50M (CLK_50M),
    .CLR     (CLR),
    .Restart (restart),
    .Tick    (tick)
  );

  always_comb begin
    nxt_state = State;
    nxt_dir   = dir_right;
    if (!Enable) nxt_state = ST_IDLE;
    else begin
      case (State)
        ST_IDLE: nxt_state = ST_FWD;
        ST_FWD: if (obst) begin
          nxt_state = ST_STOP;
          nxt_dir   = Obst_L & ~Obst_R;
        end
        ST_STOP: if (phase_end) nxt_state = ST_BACK;
        ST_BACK: if (phase_end) nxt_state = ST_TURN;
        ST_TURN: if (phase_end) begin
          if (obst) begin
            nxt_state = ST_STOP;
            nxt_dir   = Obst_L & ~Obst_R;
          end else begin
            nxt_state = ST_FWD;
          end
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  assign nxt_mot = motor_cmd(nxt_state, nxt_dir);

  // Outputs are decoded from the next state so they change with State.
  always_ff @(posedge CLK_50M) begin
    if (CLR) begin
      State     <= ST_IDLE;
      dir_right <= 1'b0;
      tcnt      <= '0;
      Motor_L   <= MOT_STOP;
      Motor_R   <= MOT_STOP;
      Busy      <= 1'b0;
    end else begin
      State     <= nxt_state;
      dir_right <= nxt_dir;
      Motor_L   <= nxt_mot.l;
      Motor_R   <= nxt_mot.r;
      Busy      <= (nxt_state == ST_STOP) || (nxt_state == ST_BACK) || (nxt_state == ST_TURN);
      if (restart)   tcnt <= '0;
      else if (tick) tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_avoid_sequencer.sv
module tb_avoid_sequencer;

  localparam int CLK_F = 20, TICK_F = 2, DIV = 10;
  localparam int ST_T = 2, BK_T = 5, TN_T = 4;

  logic CLK_50M = 1'b0, CLR = 1'b1, Enable = 1'b1, Obst_L = 1'b0, Obst_R = 1'b0;
  logic [1:0] Motor_L, Motor_R;
  logic Busy;
  logic [2:0] State;

  avoid_sequencer #(.CLK_Freq(CLK_F), .TICK_Freq(TICK_F),
                    .STOP_T(ST_T), .BACK_T(BK_T), .TURN_T(TN_T)) dut (
    .CLK_50M(CLK_50M), .CLR(CLR), .Enable(Enable), .Obst_L(Obst_L), .Obst_R(Obst_R),
    .Motor_L(Motor_L), .Motor_R(Motor_R), .Busy(Busy), .State(State));

  always #5 CLK_50M = ~CLK_50M;

  int n_chk = 0, n_fail = 0;

  // Reference model: state name, cycles left in the current phase, turn side.
  int m_st = 0, m_rem = 0, m_dir_r = 0;

  wire [7:0] dut_vec = {State, Motor_L, Motor_R, Busy};

  function automatic logic [7:0] exp_vec();
    logic [1:0] l, r;
    case (m_st)
      1: begin l = 2'b01; r = 2'b01; end
      3: begin l = 2'b10; r = 2'b10; end
      4: if (m_dir_r != 0) begin l = 2'b01; r = 2'b10; end
         else begin l = 2'b10; r = 2'b01; end
      default: begin l = 2'b00; r = 2'b00; end
    endcase
    return {m_st[2:0], l, r, (m_st >= 2 && m_st <= 4) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_step();
    if (CLR) begin m_st = 0; m_rem = 0; m_dir_r = 0; end
    else if (!Enable) m_st = 0;
    else case (m_st)
      0: m_st = 1;
      1: if (Obst_L || Obst_R) begin
           m_dir_r = (Obst_L && !Obst_R) ? 1 : 0; m_st = 2; m_rem = ST_T * DIV;
         end
      2: begin m_rem--; if (m_rem == 0) begin m_st = 3; m_rem = BK_T * DIV; end end
      3: begin m_rem--; if (m_rem == 0) begin m_st = 4; m_rem = TN_T * DIV; end end
      4: begin
           m_rem--;
           if (m_rem == 0) begin
             if (Obst_L || Obst_R) begin
               m_dir_r = (Obst_L && !Obst_R) ? 1 : 0; m_st = 2; m_rem = ST_T * DIV;
             end else m_st = 1;
           end
         end
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge CLK_50M);
    model_step();
    @(negedge CLK_50M);
  endtask

  task automatic test_reset();
    CLR = 1'b1; Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== 8'h00) begin
        n_fail++; $display("FAIL reset cyc=%0d got=%h want=00", i, dut_vec);
      end
    end
    CLR = 1'b0;
    tick();
    n_chk++;
    if (dut_vec !== {3'd1, 2'b01, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL reset_exit got=%h want=%h", dut_vec, {3'd1, 4'b0101, 1'b0});
    end
  endtask

  task automatic test_pulse_right();
    int busy_n = 0;
    Obst_R = 1'b1; tick(); Obst_R = 1'b0;
    for (int i = 0; i < 125; i++) begin
      if (i > 0) tick();
      busy_n += Busy;
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL pulse_r cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (busy_n !== 110) begin
      n_fail++; $display("FAIL pulse_r_busy got=%0d want=110", busy_n);
    end
  endtask

  task automatic test_hold_left();
    int tr_n = 0;
    Obst_L = 1'b1;
    for (int i = 0; i < 130; i++) begin
      if (i == 45) Obst_L = 1'b0;
      tick();
      if (Motor_L == 2'b01 && Motor_R == 2'b10) tr_n++;
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL hold_l cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (tr_n !== 40 || State !== 3'd1) begin
      n_fail++; $display("FAIL hold_l_turn got=%0d st=%0d want=40 st=1", tr_n, State);
    end
  endtask

  task automatic test_both_held();
    int fwd_n = 0;
    Obst_L = 1'b1; Obst_R = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (State == 3'd1) fwd_n++;
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL both cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (fwd_n !== 0) begin
      n_fail++; $display("FAIL both_nofwd got=%0d want=0", fwd_n);
    end
    Obst_L = 1'b0; Obst_R = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL both_rel cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_enable_drop();
    int busy_n = 0;
    Obst_R = 1'b1; tick(); Obst_R = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    n_chk++;
    if (dut_vec !== exp_vec() || State !== 3'd3) begin
      n_fail++; $display("FAIL en_back got=%h want=%h", dut_vec, exp_vec());
    end
    Enable = 1'b0; tick();
    n_chk++;
    if (dut_vec !== 8'h00) begin
      n_fail++; $display("FAIL en_drop got=%h want=00", dut_vec);
    end
    Enable = 1'b1; tick();
    n_chk++;
    if (dut_vec !== exp_vec() || State !== 3'd1) begin
      n_fail++; $display("FAIL en_back_fwd got=%h want=%h", dut_vec, exp_vec());
    end
    Obst_L = 1'b1; Obst_R = 1'b1; tick(); Obst_L = 1'b0; Obst_R = 1'b0;
    for (int i = 0; i < 115; i++) begin
      if (i > 0) tick();
      busy_n += Busy;
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL en_rerun cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (busy_n !== 110) begin
      n_fail++; $display("FAIL en_rerun_busy got=%0d want=110", busy_n);
    end
  endtask

  task automatic test_clr_mid_turn();
    Obst_L = 1'b1; tick(); Obst_L = 1'b0;
    for (int i = 0; i < 85; i++) tick();
    n_chk++;
    if (dut_vec !== exp_vec() || State !== 3'd4) begin
      n_fail++; $display("FAIL clr_turn_pre got=%h want=%h", dut_vec, exp_vec());
    end
    CLR = 1'b1; tick();
    n_chk++;
    if (dut_vec !== 8'h00) begin
      n_fail++; $display("FAIL clr_turn got=%h want=00", dut_vec);
    end
    CLR = 1'b0; tick();
    n_chk++;
    if (dut_vec !== {3'd1, 4'b0101, 1'b0}) begin
      n_fail++; $display("FAIL clr_turn_fwd got=%h want=%h", dut_vec, {3'd1, 4'b0101, 1'b0});
    end
  endtask

  task automatic test_illegal_state();
    force dut.State = 3'd6;
    m_st = 6;
    #1 release dut.State;
    tick();
    n_chk++;
    if (dut_vec !== 8'h00) begin
      n_fail++; $display("FAIL illegal got=%h want=00", dut_vec);
    end
    tick();
    n_chk++;
    if (dut_vec !== exp_vec() || State !== 3'd1) begin
      n_fail++; $display("FAIL illegal_fwd got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      CLR    = ($urandom_range(0, 599) == 0);
      Enable = ($urandom_range(0, 249) != 0);
      Obst_L = ($urandom_range(0, 49) == 0);
      Obst_R = ($urandom_range(0, 49) == 0);
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    CLR = 1'b0; Enable = 1'b1; Obst_L = 1'b0; Obst_R = 1'b0;
  endtask

  initial begin
    @(negedge CLK_50M);
    test_reset();
    test_pulse_right();
    test_hold_left();
    test_both_held();
    test_enable_drop();
    test_clr_mid_turn();
    test_illegal_state();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
